// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the datapath.
// The master side is the FSM: it consumes instruction fields and status,
// and drives the datapath enables and ALU selection fields.
interface multicycle_control_if;
  // Instruction fields and datapath status
  logic [6:0] opcode;
  logic       instr_bit30;
  logic [2:0] funct3;
  logic       mem_ready;
  logic       zero;

  // Datapath control
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       ior_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [3:0] alu_instr;
  logic       retire;
  logic       fault;

  modport master (
    input  opcode, instr_bit30, funct3, mem_ready, zero,
    output pc_write, pc_write_cond, pc_source, ior_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           alu_instr, retire, fault
  );

  modport slave (
    output opcode, instr_bit30, funct3, mem_ready, zero,
    input  pc_write, pc_write_cond, pc_source, ior_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           alu_instr, retire, fault
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I-subset core.
// Sequences FETCH / DECODE / EXECUTE / MEM / WB, waits on variable-latency
// memory with a bounded wait counter, and latches a sticky fault on an
// illegal opcode or a memory timeout. Moore outputs are registered from the
// next state; only the mem_ready-qualified strobes are combined afterwards.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  n_rst,
  multicycle_control_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_I_EXEC    = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_FAULT     = 4'd12
  } state_t;

  // Registered Moore control word. in_fetch / in_mem_write mark the states
  // whose strobes are qualified by mem_ready outside the register.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       fault;
    logic       in_fetch;
    logic       in_mem_write;
  } ctrl_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  ctrl_t            ctrl;
  logic             timed_out;

  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

  // Moore output table; anything not set for a state stays 0.
  function automatic ctrl_t decode_state(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.in_fetch  = 1'b1;
      end
      S_DECODE: begin
        // Branch / jump target PC+imm is precomputed into ALUOut here.
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b10;
      end
      S_R_EXEC: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      S_I_EXEC: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b01;
        c.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write    = 1'b1;
        c.ior_d        = 1'b1;
        c.in_mem_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 2'b01;
        c.alu_src_b     = 2'b00;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.retire        = 1'b1;
      end
      S_JAL: begin
        // Link value is the PC already advanced to PC+4 during FETCH.
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b01;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b10;
        c.retire     = 1'b1;
      end
      S_FAULT: begin
        c.fault = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next-state selection, including opcode dispatch and memory timeout.
  always_comb begin
    nxt       = state;
    timed_out = (wait_cnt == CNT_MAX) && !bus.mem_ready;
    case (state)
      S_RESET:  nxt = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  nxt = S_DECODE;
        else if (timed_out) nxt = S_FAULT;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:           nxt = S_R_EXEC;
          OP_ITYPE:           nxt = S_I_EXEC;
          OP_LOAD, OP_STORE:  nxt = S_MEM_ADDR;
          OP_BRANCH:          nxt = S_BRANCH;
          OP_JAL:             nxt = S_JAL;
          default:            nxt = S_FAULT;
        endcase
      end
      S_R_EXEC:   nxt = S_ALU_WB;
      S_I_EXEC:   nxt = S_ALU_WB;
      S_ALU_WB:   nxt = S_FETCH;
      S_MEM_ADDR: nxt = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.mem_ready)  nxt = S_MEM_WB;
        else if (timed_out) nxt = S_FAULT;
      end
      S_MEM_WB:   nxt = S_FETCH;
      S_MEM_WRITE: begin
        if (bus.mem_ready)  nxt = S_FETCH;
        else if (timed_out) nxt = S_FAULT;
      end
      S_BRANCH:   nxt = S_FETCH;
      S_JAL:      nxt = S_FETCH;
      S_FAULT:    nxt = S_FAULT;
      default:    nxt = S_FAULT;
    endcase
  end

  // State, wait counter and registered Moore outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      ctrl     <= '0;
    end else begin
      state <= nxt;
      ctrl  <= decode_state(nxt);
      if (is_mem_state(nxt) && (nxt != state)) begin
        wait_cnt <= '0;
      end else if (is_mem_state(state) && (nxt == state) && !bus.mem_ready &&
                   (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Strobes qualified by mem_ready complete the access in the same cycle.
  assign bus.ir_write      = ctrl.in_fetch & bus.mem_ready;
  assign bus.pc_write      = ctrl.pc_write | (ctrl.in_fetch & bus.mem_ready);
  assign bus.retire        = ctrl.retire | (ctrl.in_mem_write & bus.mem_ready);
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.ior_d         = ctrl.ior_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.fault         = ctrl.fault;

  // Only R-type carries the SUB/SRA selector in bit30; immediates never do.
  assign bus.alu_instr = {(bus.opcode == OP_RTYPE) ? bus.instr_bit30 : 1'b0, bus.funct3};

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: each record is one clock cycle
// of inputs plus the state whose outputs are expected in that cycle.
module tb_multicycle_control;

  typedef enum {
    T_RESET, T_FETCH, T_DECODE, T_R_EXEC, T_I_EXEC, T_ALU_WB, T_MEM_ADDR,
    T_MEM_READ, T_MEM_WB, T_MEM_WRITE, T_BRANCH, T_JAL, T_FAULT
  } tst_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] alu_instr;
    logic       retire;
    logic       fault;
  } out_t;

  typedef struct {
    int         sel;
    logic       nr;
    tst_e       st;
    logic [6:0] op;
    logic       b30;
    logic [2:0] f3;
    logic       mr;
    logic       z;
  } vec_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_ILL = 7'b1111111;

  logic       clk = 1'b0;
  logic       n_rst1;
  logic       n_rst2;
  logic [6:0] opcode = '0;
  logic       instr_bit30 = 1'b0;
  logic [2:0] funct3 = '0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;

  multicycle_control_if b1 ();
  multicycle_control_if b2 ();

  assign b1.opcode = opcode;      assign b2.opcode = opcode;
  assign b1.instr_bit30 = instr_bit30; assign b2.instr_bit30 = instr_bit30;
  assign b1.funct3 = funct3;      assign b2.funct3 = funct3;
  assign b1.mem_ready = mem_ready; assign b2.mem_ready = mem_ready;
  assign b1.zero = zero;          assign b2.zero = zero;

  multicycle_control #(.TIMEOUT_CYCLES(255)) dut1 (.clk(clk), .n_rst(n_rst1), .bus(b1));
  multicycle_control #(.TIMEOUT_CYCLES(4))   dut2 (.clk(clk), .n_rst(n_rst2), .bus(b2));

  out_t got1, got2;
  assign got1 = {b1.pc_write, b1.pc_write_cond, b1.pc_source, b1.ior_d, b1.mem_read,
                 b1.mem_write, b1.ir_write, b1.mem_to_reg, b1.reg_write, b1.alu_src_a,
                 b1.alu_src_b, b1.alu_op, b1.alu_instr, b1.retire, b1.fault};
  assign got2 = {b2.pc_write, b2.pc_write_cond, b2.pc_source, b2.ior_d, b2.mem_read,
                 b2.mem_write, b2.ir_write, b2.mem_to_reg, b2.reg_write, b2.alu_src_a,
                 b2.alu_src_b, b2.alu_op, b2.alu_instr, b2.retire, b2.fault};

  always #5 clk = ~clk;

  vec_t tbl[$];
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int sel, logic nr, tst_e st, logic [6:0] op,
                              logic b30, logic [2:0] f3, logic mr, logic z);
    vec_t v;
    v.sel = sel; v.nr = nr; v.st = st; v.op = op;
    v.b30 = b30; v.f3 = f3; v.mr = mr; v.z = z;
    tbl.push_back(v);
  endfunction

  task automatic chk(int step, int dut, string tag, out_t g, out_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL step %0d dut%0d %s: got %h required %h", step, dut, tag, g, e);
    end
  endtask

  // Expected outputs for a state, written out from the control table.
  function automatic out_t exp_out(vec_t v);
    out_t o;
    o = '0;
    o.alu_instr = {(v.op == OP_R) ? v.b30 : 1'b0, v.f3};
    case (v.st)
      T_FETCH:     begin o.mem_read = 1; o.alu_src_b = 2'b01;
                         o.ir_write = v.mr; o.pc_write = v.mr; end
      T_DECODE:    begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b10; end
      T_R_EXEC:    begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b00; o.alu_op = 2'b10; end
      T_I_EXEC:    begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_op = 2'b10; end
      T_ALU_WB:    begin o.reg_write = 1; o.retire = 1; end
      T_MEM_ADDR:  begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; end
      T_MEM_READ:  begin o.mem_read = 1; o.ior_d = 1; end
      T_MEM_WB:    begin o.reg_write = 1; o.mem_to_reg = 2'b01; o.retire = 1; end
      T_MEM_WRITE: begin o.mem_write = 1; o.ior_d = 1; o.retire = v.mr; end
      T_BRANCH:    begin o.alu_src_a = 2'b01; o.alu_op = 2'b01; o.pc_write_cond = 1;
                         o.pc_source = 2'b01; o.retire = 1; end
      T_JAL:       begin o.pc_write = 1; o.pc_source = 2'b01; o.reg_write = 1;
                         o.mem_to_reg = 2'b10; o.retire = 1; end
      T_FAULT:     o.fault = 1;
      default:     ;
    endcase
    return o;
  endfunction

  initial begin
    out_t e;
    n_rst1 = 1'b1;
    n_rst2 = 1'b1;
    #1;
    n_rst1 = 1'b0;
    n_rst2 = 1'b0;

    // ---- DUT1 (TIMEOUT_CYCLES=255) ----
    add(0, 0, T_RESET, 7'd0, 0, 3'd0, 1, 0);
    add(0, 0, T_RESET, 7'd0, 0, 3'd0, 1, 0);
    add(0, 1, T_RESET, OP_R, 0, 3'd0, 1, 0);
    // add
    add(0, 1, T_FETCH, OP_R, 0, 3'b000, 1, 0);
    add(0, 1, T_DECODE, OP_R, 0, 3'b000, 1, 0);
    add(0, 1, T_R_EXEC, OP_R, 0, 3'b000, 1, 0);
    add(0, 1, T_ALU_WB, OP_R, 0, 3'b000, 1, 0);
    // sub
    add(0, 1, T_FETCH, OP_R, 1, 3'b000, 1, 0);
    add(0, 1, T_DECODE, OP_R, 1, 3'b000, 0, 0);
    add(0, 1, T_R_EXEC, OP_R, 1, 3'b000, 0, 0);
    add(0, 1, T_ALU_WB, OP_R, 1, 3'b000, 0, 0);
    // addi with bit30 set must not become SUB
    add(0, 1, T_FETCH, OP_I, 1, 3'b000, 1, 0);
    add(0, 1, T_DECODE, OP_I, 1, 3'b000, 1, 0);
    add(0, 1, T_I_EXEC, OP_I, 1, 3'b000, 1, 0);
    add(0, 1, T_ALU_WB, OP_I, 1, 3'b000, 1, 0);
    // R-type funct3=100 bit30=1 with a one-cycle fetch stall
    add(0, 1, T_FETCH, OP_R, 1, 3'b100, 0, 0);
    add(0, 1, T_FETCH, OP_R, 1, 3'b100, 1, 0);
    add(0, 1, T_DECODE, OP_R, 1, 3'b100, 1, 0);
    add(0, 1, T_R_EXEC, OP_R, 1, 3'b100, 1, 0);
    add(0, 1, T_ALU_WB, OP_R, 1, 3'b100, 1, 0);
    // I-type funct3=010 bit30=1
    add(0, 1, T_FETCH, OP_I, 1, 3'b010, 1, 0);
    add(0, 1, T_DECODE, OP_I, 1, 3'b010, 1, 0);
    add(0, 1, T_I_EXEC, OP_I, 1, 3'b010, 1, 0);
    add(0, 1, T_ALU_WB, OP_I, 1, 3'b010, 1, 0);
    // lw with three wait cycles: 8 cycles total
    add(0, 1, T_FETCH, OP_LD, 0, 3'b010, 1, 0);
    add(0, 1, T_DECODE, OP_LD, 0, 3'b010, 0, 0);
    add(0, 1, T_MEM_ADDR, OP_LD, 0, 3'b010, 0, 0);
    add(0, 1, T_MEM_READ, OP_LD, 0, 3'b010, 0, 0);
    add(0, 1, T_MEM_READ, OP_LD, 0, 3'b010, 0, 0);
    add(0, 1, T_MEM_READ, OP_LD, 0, 3'b010, 0, 0);
    add(0, 1, T_MEM_READ, OP_LD, 0, 3'b010, 1, 0);
    add(0, 1, T_MEM_WB, OP_LD, 0, 3'b010, 1, 0);
    // beq taken / not taken
    add(0, 1, T_FETCH, OP_BR, 0, 3'b000, 1, 1);
    add(0, 1, T_DECODE, OP_BR, 0, 3'b000, 1, 1);
    add(0, 1, T_BRANCH, OP_BR, 0, 3'b000, 1, 1);
    add(0, 1, T_FETCH, OP_BR, 0, 3'b000, 1, 0);
    add(0, 1, T_DECODE, OP_BR, 0, 3'b000, 1, 0);
    add(0, 1, T_BRANCH, OP_BR, 0, 3'b000, 1, 0);
    // jal
    add(0, 1, T_FETCH, OP_JAL, 0, 3'b000, 1, 0);
    add(0, 1, T_DECODE, OP_JAL, 0, 3'b000, 1, 0);
    add(0, 1, T_JAL, OP_JAL, 0, 3'b000, 1, 0);
    // sw: retire coincident with mem_ready
    add(0, 1, T_FETCH, OP_ST, 0, 3'b010, 1, 0);
    add(0, 1, T_DECODE, OP_ST, 0, 3'b010, 1, 0);
    add(0, 1, T_MEM_ADDR, OP_ST, 0, 3'b010, 1, 0);
    add(0, 1, T_MEM_WRITE, OP_ST, 0, 3'b010, 0, 0);
    add(0, 1, T_MEM_WRITE, OP_ST, 0, 3'b010, 1, 0);
    // sw aborted by reset mid-store: no strobe survives
    add(0, 1, T_FETCH, OP_ST, 0, 3'b010, 1, 0);
    add(0, 1, T_DECODE, OP_ST, 0, 3'b010, 1, 0);
    add(0, 1, T_MEM_ADDR, OP_ST, 0, 3'b010, 1, 0);
    add(0, 1, T_MEM_WRITE, OP_ST, 0, 3'b010, 0, 0);
    add(0, 0, T_RESET, 7'd0, 0, 3'd0, 1, 0);
    add(0, 1, T_RESET, OP_ILL, 0, 3'd0, 1, 0);
    // illegal opcode -> sticky fault
    add(0, 1, T_FETCH, OP_ILL, 0, 3'd0, 1, 0);
    add(0, 1, T_DECODE, OP_ILL, 0, 3'd0, 1, 0);
    for (int k = 0; k < 10; k++) add(0, 1, T_FAULT, OP_ILL, 0, 3'd0, logic'(k % 2), 0);
    add(0, 0, T_RESET, 7'd0, 0, 3'd0, 1, 0);

    // ---- DUT2 (TIMEOUT_CYCLES=4) ----
    // mem_ready arriving exactly at the timeout count still wins
    add(1, 0, T_RESET, 7'd0, 0, 3'd0, 0, 0);
    add(1, 1, T_RESET, OP_R, 0, 3'd0, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 1, T_FETCH, OP_R, 0, 3'd0, 0, 0);
    add(1, 1, T_FETCH, OP_R, 0, 3'd0, 1, 0);
    add(1, 1, T_DECODE, OP_R, 0, 3'd0, 0, 0);
    // mem_ready stuck low -> fault
    add(1, 0, T_RESET, 7'd0, 0, 3'd0, 0, 0);
    add(1, 1, T_RESET, 7'd0, 0, 3'd0, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 1, T_FETCH, 7'd0, 0, 3'd0, 0, 0);
    add(1, 1, T_FAULT, 7'd0, 0, 3'd0, 0, 0);
    add(1, 1, T_FAULT, 7'd0, 0, 3'd0, 1, 0);
    add(1, 1, T_FAULT, 7'd0, 0, 3'd0, 1, 0);
    add(1, 0, T_RESET, 7'd0, 0, 3'd0, 1, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      opcode      = tbl[i].op;
      instr_bit30 = tbl[i].b30;
      funct3      = tbl[i].f3;
      mem_ready   = tbl[i].mr;
      zero        = tbl[i].z;
      if (tbl[i].sel == 0) n_rst1 = tbl[i].nr;
      else                 n_rst2 = tbl[i].nr;
      exp_q.push_back(exp_out(tbl[i]));
      #2;
      e = exp_q.pop_front();
      if (tbl[i].sel == 0) chk(i, 1, tbl[i].st.name(), got1, e);
      else                 chk(i, 2, tbl[i].st.name(), got2, e);
    end

    @(negedge clk);
    opcode    = '0;
    funct3    = '0;
    mem_ready = 1'b1;
    #2;
    chk(tbl.size(), 1, "RESET_HOLD", got1, out_t'(0));
    chk(tbl.size(), 2, "RESET_HOLD", got2, out_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I subset core; sits directly upstream of ALU_control.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB, and drives datapath enables, ALUOp[1:0] and the 4-bit {bit30,funct3} field consumed by ALU_control.
- Handles variable-latency memory via mem_ready with a timeout.
- Enters a sticky fault state on an illegal opcode or a memory timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready in any memory state before faulting; wait counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- instr_bit30  in  1  IR[30].
- funct3  in  3  IR[14:12].
- mem_ready  in  1  memory access complete this cycle.
- zero  in  1  ALU zero flag.
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  PC write if zero.
- pc_source  out  2  00 ALU result, 01 ALUOut.
- ior_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR and OldPC.
- mem_to_reg  out  2  write-back data: 00 ALUOut, 01 MDR, 10 PC.
- reg_write  out  1  register file write.
- alu_src_a  out  2  ALU A input: 00 PC, 01 A reg, 10 OldPC.
- alu_src_b  out  2  ALU B input: 00 B reg, 01 constant 4, 10 immediate.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- alu_instr  out  4  {opcode==0110011 ? instr_bit30 : 0, funct3}; feeds ALU_control.
- retire  out  1  one-cycle pulse in the final state of each instruction.
- fault  out  1  sticky fault indicator.

Behaviour:
- Moore FSM: all outputs are decoded from the state register, except where noted as qualified by mem_ready or zero. alu_instr is purely combinational from its inputs.
- Any output not listed for a state is 0.
- n_rst low: state=RESET and wait counter=0; all outputs 0. RESET lasts exactly one cycle after n_rst deasserts, then goes to FETCH.
- FETCH:
  - Drives mem_read=1, ior_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=10, alu_src_b=10, alu_op=00 (branch/jump target into ALUOut).
  - Next state by opcode: 0110011 R_EXEC; 0010011 I_EXEC; 0000011 or 0100011 MEM_ADDR; 1100011 BRANCH; 1101111 JAL; any other FAULT.
- R_EXEC: alu_src_a=01, alu_src_b=00, alu_op=10; next ALU_WB.
- I_EXEC: alu_src_a=01, alu_src_b=10, alu_op=10; next ALU_WB. Because alu_instr[3]=0 here, addi never decodes as SUB.
- ALU_WB: reg_write=1, mem_to_reg=00, retire=1; next FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00; next MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: mem_read=1, ior_d=1; stays until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01, retire=1; next FETCH.
- MEM_WRITE: mem_write=1, ior_d=1; retire=mem_ready; stays until mem_ready, then goes to FETCH.
- BRANCH (beq only): alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retire=1; next FETCH.
- JAL: pc_write=1, pc_source=01, reg_write=1, mem_to_reg=10, retire=1; next FETCH.
  - mem_to_reg=10 writes the PC that was already incremented in FETCH, i.e. the link value PC+4.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle the FSM stays in one of those states with mem_ready=0; saturates.
  - If the counter equals TIMEOUT_CYCLES and mem_ready=0, next state is FAULT.
  - mem_ready=1 in that same cycle wins: the access completes normally.
- FAULT: fault=1, all enables 0. Exit only via n_rst.
- mem_ready outside a memory state is ignored.
- Reset mid-instruction aborts immediately; no partial write enable is asserted after n_rst falls.

Test Plan:
- Reset, then n_rst=1 with mem_ready=1 held -> RESET for 1 cycle, then FETCH with ir_write=pc_write=1 and mem_read=1.
- add (opcode 0110011, bit30=0, funct3=000), mem_ready=1 -> FETCH, DECODE, R_EXEC, ALU_WB in 4 cycles. alu_op=10 and alu_instr=0000 in R_EXEC; reg_write=1 and retire=1 in ALU_WB.
- sub (bit30=1) -> alu_instr=1000 in R_EXEC. addi with bit30=1 (opcode 0010011) -> alu_instr=0000, alu_op=10 in I_EXEC.
- lw with mem_ready low 3 cycles in MEM_READ -> state held 4 cycles, then MEM_WB with mem_to_reg=01 and reg_write=1. Total 8 cycles.
- beq with zero=1 and with zero=0 -> BRANCH asserts pc_write_cond=1, alu_op=01, pc_source=01, retire=1 in both cases; next FETCH. sw completes with retire coincident with mem_ready.
- Opcode 1111111 -> FAULT after DECODE, fault=1, stays through 10 cycles. Separately, TIMEOUT_CYCLES=4 with mem_ready stuck at 0 in FETCH -> FAULT on the cycle after the counter reaches 4. n_rst low -> outputs 0 and fault=0 immediately.
